// File: rtl/crash_detect.sv
// crash_detect: pixel-level collision detector with a player life and
// invulnerability state machine. Crash outputs are combinational from the
// alpha inputs of the pixel being scanned, gated by the registered game state.

module crash_detect #(
  parameter int LIVES          = 3,
  parameter int LIVES_BIT_LEN  = 2,
  parameter int INVULN_FRAMES  = 120,
  parameter int INVULN_BIT_LEN = 7
) (
  input  logic                     clk_vga,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     v_sync_i,
  input  logic                     enemy_alpha_i,
  input  logic                     bullet_alpha_i,
  input  logic                     me_alpha_i,
  output logic                     crash_enemy_bullet_o,
  output logic                     crash_me_enemy_o,
  output logic [LIVES_BIT_LEN-1:0] lives_o,
  output logic                     invuln_o,
  output logic                     game_over_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACTIVE,
    ST_INVULN,
    ST_OVER
  } state_t;

  localparam logic [LIVES_BIT_LEN-1:0]  LIVES_INIT  = LIVES_BIT_LEN'(LIVES);
  localparam logic [LIVES_BIT_LEN-1:0]  LIVES_ONE   = LIVES_BIT_LEN'(1);
  localparam logic [INVULN_BIT_LEN-1:0] INVULN_LOAD = INVULN_BIT_LEN'(INVULN_FRAMES);
  localparam logic [INVULN_BIT_LEN-1:0] CNT_ONE     = INVULN_BIT_LEN'(1);

  state_t                    state_q, state_d;
  logic [LIVES_BIT_LEN-1:0]  lives_q, lives_d;
  logic [INVULN_BIT_LEN-1:0] cnt_q, cnt_d;
  logic                      v_sync_q, v_sync_d;
  logic                      invuln_q, invuln_d;
  logic                      game_over_q, game_over_d;

  logic fs;
  logic ob;
  logic om;

  // Frame start and per-pixel overlap terms.
  always_comb begin
    fs       = v_sync_q & ~v_sync_i;
    ob       = enemy_alpha_i & bullet_alpha_i;
    om       = enemy_alpha_i & me_alpha_i;
    v_sync_d = v_sync_i;
  end

  // Next-state logic: disabling the game overrides every other transition.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
    state_d = state_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = ST_IDLE;
      lives_d = LIVES_INIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lives_d = LIVES_INIT;
          state_d = ST_ARM;
        end
        ST_ARM: begin
          // Wait for a clean frame so no crash comes from a partial frame.
          if (fs) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (om) begin
            if (lives_q > LIVES_ONE) begin
              lives_d = lives_q - LIVES_ONE;
              cnt_d   = INVULN_LOAD;
              state_d = ST_INVULN;
            end else begin
              lives_d = '0;
              state_d = ST_OVER;
            end
          end
        end
        ST_INVULN: begin
          // Player hits are ignored; only frame starts matter here.
          if (fs) begin
            if (cnt_q <= CNT_ONE) begin
              cnt_d   = '0;
              state_d = ST_ACTIVE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_IDLE;
          lives_d = LIVES_INIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Registered status outputs decoded from the next state.
  always_comb begin
    invuln_d    = (state_d == ST_INVULN);
    game_over_d = (state_d == ST_OVER);
  end

  // State, counters, v_sync delay and status flops.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      cnt_q       <= '0;
      v_sync_q    <= 1'b1;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      v_sync_q    <= v_sync_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  // Zero-latency crash outputs, gated by registered state and the enable.
  always_comb begin
    crash_enemy_bullet_o = ob & en_i &
                           ((state_q == ST_ACTIVE) | (state_q == ST_INVULN));
    crash_me_enemy_o     = om & en_i & (state_q == ST_ACTIVE);
    lives_o              = lives_q;
    invuln_o             = invuln_q;
    game_over_o          = game_over_q;
  end

endmodule

// File: doc/crash_detect.md
# crash_detect

Pixel-level collision detector that drives the `crash_enemy_bullet_i` / `crash_me_enemy_i` inputs of every enemy sprite module. It sits beside the layer mixer in the `clk_vga` domain. Each cycle it ANDs the alpha bits of the enemy, bullet and player layers for the pixel currently being scanned, which keeps it aligned with each enemy's `curr_enemy_idx`. A player life/invulnerability state machine gates the player-crash output and raises game-over.

## Interface
- `LIVES`, default 3: lives loaded at reset and at game restart.
- `LIVES_BIT_LEN`, default 2: width of the lives counter.
- `INVULN_FRAMES`, default 120: frames of player invulnerability after a hit.
- `INVULN_BIT_LEN`, default 7: width of the invulnerability frame counter.

Ports (clock and reset first):
- `clk_vga` input 1: pixel clock, the only clock.
- `rst` input 1: asynchronous, active-high reset.
- `en_i` input 1: game running. Low means stop and reload for a new game.
- `v_sync_i` input 1: VGA vertical sync, active low.
- `enemy_alpha_i` input 1: OR of all enemy layers' `vga_alpha_o` for the current pixel.
- `bullet_alpha_i` input 1: bullet layer alpha for the current pixel.
- `me_alpha_i` input 1: player layer alpha for the current pixel.
- `crash_enemy_bullet_o` output 1: enemy/bullet overlap on the current pixel.
- `crash_me_enemy_o` output 1: enemy/player hit, a single-cycle pulse.
- `lives_o` output `LIVES_BIT_LEN`: remaining lives.
- `invuln_o` output 1: high while the player is invulnerable. The player module uses it for blinking.
- `game_over_o` output 1: high in the OVER state.

## Operation
- Frame start (`fs`): registered falling edge of `v_sync_i`. Uses a one-flop delay of `v_sync_i`; `fs` = delayed & ~current. `fs` is a one-cycle internal pulse.
- Overlap terms, combinational from the inputs:
  - `ob` = `enemy_alpha_i & bullet_alpha_i`
  - `om` = `enemy_alpha_i & me_alpha_i`
- State machine states: IDLE, ARM, ACTIVE, INVULN, OVER. Reset state is IDLE.
  - IDLE: lives = `LIVES`. Goes to ARM when `en_i` = 1.
  - ARM: waits for a clean frame boundary. Goes to ACTIVE on `fs`.
  - ACTIVE, on `om`:
    - If `lives_o` > 1: decrement lives, load the invulnerability counter with `INVULN_FRAMES`, go to INVULN.
    - If `lives_o` == 1: lives → 0, go to OVER.
  - INVULN: on each `fs` the counter decrements. When `fs` arrives with counter == 1, go to ACTIVE. `om` is ignored.
  - OVER: holds.
  - `en_i` = 0 in any state: go to IDLE on the next edge, reload lives, clear the counter. This takes priority over every other transition.
- Output decode:
  - `crash_enemy_bullet_o` = `ob` & (state ∈ {ACTIVE, INVULN}) & `en_i`. It is asserted on every overlapping pixel. Each enemy module acts only on its first pulse.
  - `crash_me_enemy_o` = `om` & (state == ACTIVE) & `en_i`. The state leaves ACTIVE on the next edge, so the pulse is one cycle.
  - `invuln_o` = (state == INVULN).
  - `game_over_o` = (state == OVER).
  - `lives_o` = lives register.
- Arithmetic: lives never decrements below 0. The counter never wraps, because loading happens only on INVULN entry.

## Timing
- Crash outputs have zero latency: combinational from the alpha inputs, gated by registered state. They must be valid in the same `clk_vga` cycle as the pixel.
- Registered outputs change on the edge after the triggering cycle: `lives_o`, `invuln_o`, `game_over_o`.
- Values during reset: `crash_*_o` = 0, `lives_o` = `LIVES`, `invuln_o` = 0, `game_over_o` = 0, state = IDLE, v_sync delay flop = 1.
- `fs` is one cycle after the `v_sync_i` falling edge.
- ARM→ACTIVE takes effect on the edge after `fs`. No crash is reported in the partial frame after `en_i` rises.
- Simultaneous events:
  - `ob` and `om` in the same ACTIVE cycle: both outputs high.
  - `fs` and `om` in the same INVULN cycle with counter == 1: go to ACTIVE. That `om` is not reported.
  - `en_i` falling while `om` is present: no crash reported, because outputs are gated by `en_i`. Go to IDLE.
- Reset mid-frame: all state clears immediately (asynchronous). Re-arming requires `en_i` and a fresh `fs`.

## Test plan
- Reset, then `en_i` = 1 mid-frame with `ob` held high:
  - Both crash outputs stay 0 until the cycle after the first `fs`.
  - From then, `crash_enemy_bullet_o` = `ob` each cycle.
- ACTIVE with `LIVES` = 3, drive `om` for 5 consecutive cycles:
  - `crash_me_enemy_o` is high for exactly 1 cycle.
  - `lives_o` = 2 and `invuln_o` = 1 on the next edge.
- INVULN with `INVULN_FRAMES` = 4 (bench override):
  - `om` is ignored and `ob` is still reported.
  - `invuln_o` falls on the edge after the 4th `fs`.
- Three hits, each separated by the full invulnerability period:
  - `lives_o` goes 3→2→1→0.
  - `game_over_o` = 1 after the third hit, and all crash outputs stay 0 afterwards.
- In OVER, drop `en_i` for 1 cycle, then raise it:
  - IDLE, with `lives_o` = 3 and `game_over_o` = 0.
  - Re-arms on the next `fs`.
- Assert `rst` mid-INVULN:
  - All outputs take their reset values asynchronously.
  - After `rst` is released, a crash is reported only after `en_i` and the next `fs`.
